sram_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the external 256K×16 SRAM controller between the 65xx bus (port 0) and a second bus master such as a DMA or video fetcher (port 1). It sits between the requesters and the `sram` controller. It latches one request at a time, drives the controller's strobes until `mem_ready`, and returns read data with a one-cycle acknowledge. A watchdog aborts any access that the controller never completes.

---
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter and sequencer in front of the 256Kx16 SRAM controller.
// Latches one request, holds the strobes until mem_ready or a watchdog abort, then acks once.
module sram_arbiter #(
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [17:0] addr0,
    input  logic [17:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [17:0] mem_address,
    output logic [15:0] mem_data_write,
    input  logic [15:0] mem_data_read,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic        busy,
    output logic        owner
);
    localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

    state_e      state_q;
    logic        we_q;
    logic [3:0]  starve_q;
    logic [7:0]  wdog_q;
    logic        owner_q;
    logic        busy_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [17:0] mem_address_q;
    logic [15:0] mem_data_write_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        err0_q;
    logic        err1_q;
    logic [15:0] rdata0_q;
    logic [15:0] rdata1_q;

    logic        win1;
    logic        win_we;
    logic        access_done;
    logic        rdata_upd;
    logic [15:0] rdata_cap;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        win1 = req1;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0) win1 = (starve_q == STARVE_MAX);
            else                 win1 = ~owner_q;
        end
        win_we      = win1 ? we1 : we0;
        // mem_ready on the timeout cycle still counts as a normal completion.
        access_done = mem_ready || (wdog_q == TIMEOUT_CNT);
        rdata_upd   = !we_q || !mem_ready;
        rdata_cap   = mem_ready ? mem_data_read : 16'hFFFF;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            we_q             <= 1'b0;
            starve_q         <= 4'd0;
            wdog_q           <= 8'd0;
            owner_q          <= 1'b1;
            busy_q           <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= 18'd0;
            mem_data_write_q <= 16'd0;
            ack0_q           <= 1'b0;
            ack1_q           <= 1'b0;
            err0_q           <= 1'b0;
            err1_q           <= 1'b0;
            rdata0_q         <= 16'd0;
            rdata1_q         <= 16'd0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q          <= BUSY;
                        busy_q           <= 1'b1;
                        owner_q          <= win1;
                        wdog_q           <= 8'd0;
                        we_q             <= win_we;
                        mem_read_q       <= ~win_we;
                        mem_write_q      <= win_we;
                        mem_address_q    <= win1 ? addr1 : addr0;
                        mem_data_write_q <= win1 ? wdata1 : wdata0;
                        if (win1 || !req1) starve_q <= 4'd0;
                        else               starve_q <= starve_q + 4'd1;
                    end
                end
                BUSY: begin
                    if (access_done) begin
                        state_q     <= ACK;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (owner_q) begin
                            ack1_q <= 1'b1;
                            err1_q <= ~mem_ready;
                            if (rdata_upd) rdata1_q <= rdata_cap;
                        end else begin
                            ack0_q <= 1'b1;
                            err0_q <= ~mem_ready;
                            if (rdata_upd) rdata0_q <= rdata_cap;
                        end
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign err0           = err0_q;
    assign err1           = err1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign mem_address    = mem_address_q;
    assign mem_data_write = mem_data_write_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign busy           = busy_q;
    assign owner          = owner_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin and a fixed-priority instance, each with bench-owned
// requesters, an SRAM controller model, a grant/response reference model and a response monitor.
module tb_sram_arbiter;
    localparam int TO     = 8;
    localparam int STARVE = 4;

    typedef struct {
        int          port;
        logic        err;
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef enum int {M_OFF, M_HOLD, M_RAND} mode_e;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    for (genvar d = 0; d < 2; d++) begin : g_env
        logic        rst_n = 1'b0;
        logic        req [2];
        logic        we [2];
        logic [17:0] addr [2];
        logic [15:0] wdata [2];
        logic        ack0, ack1, err0, err1, mem_read, mem_write, busy, owner;
        logic [15:0] rdata0, rdata1, mem_data_write;
        logic [17:0] mem_address;
        logic        mem_ready = 1'b0;
        logic [15:0] mem_data_read = 16'd0;

        bit          done = 1'b0;
        bit          stall = 1'b0;
        int          lat_ovr = -1;
        mode_e       mode = M_OFF;
        int          cyc = 0;
        logic [1:0]  req_snap = 2'b00;

        exp_t        exp_q [$];
        int          grant_log [$];
        int          grant_cyc [$];
        logic [15:0] mem [logic [17:0]];

        sram_arbiter #(
            .FIXED_PRIO  (d),
            .STARVE_LIMIT(STARVE),
            .TIMEOUT     (TO)
        ) dut (
            .clk           (clk),
            .reset_n       (rst_n),
            .req0          (req[0]),
            .req1          (req[1]),
            .we0           (we[0]),
            .we1           (we[1]),
            .addr0         (addr[0]),
            .addr1         (addr[1]),
            .wdata0        (wdata[0]),
            .wdata1        (wdata[1]),
            .ack0          (ack0),
            .ack1          (ack1),
            .err0          (err0),
            .err1          (err1),
            .rdata0        (rdata0),
            .rdata1        (rdata1),
            .mem_address   (mem_address),
            .mem_data_write(mem_data_write),
            .mem_data_read (mem_data_read),
            .mem_read      (mem_read),
            .mem_write     (mem_write),
            .mem_ready     (mem_ready),
            .busy          (busy),
            .owner         (owner)
        );

        always @(posedge clk) cyc <= cyc + 1;
        always @(posedge clk) req_snap <= {req[1], req[0]};

        task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
            check($sformatf("e%0d_%s", d, n), a, e);
        endtask

        // Reference model state: arbitration history and last read data per port.
        bit          m_owner = 1'b1;
        int          m_starve = 0;
        logic [15:0] last_rd [2];
        bit          r_active = 1'b0;
        bit          r_to = 1'b0;
        int          r_cnt = 0;
        int          r_lat = 0;

        task automatic start_access();
            int          win;
            int          r;
            logic [15:0] data;
            exp_t        e;
            chk("grant_had_req", 32'(req_snap != 2'b00), 32'd1);
            case (req_snap)
                2'b10:   win = 1;
                2'b11:   win = (d == 1) ? ((m_starve == STARVE) ? 1 : 0) : (m_owner ? 0 : 1);
                default: win = 0;
            endcase
            if (win == 1 || !req_snap[1]) m_starve = 0;
            else                          m_starve++;
            m_owner = (win == 1);
            grant_log.push_back(win);
            grant_cyc.push_back(cyc);
            chk("grant_addr", 32'(mem_address), 32'(addr[win]));
            chk("grant_dir", 32'({mem_write, mem_read}), we[win] ? 32'd2 : 32'd1);
            chk("grant_busy_owner", 32'({busy, owner}), 32'({1'b1, m_owner}));
            if (we[win]) chk("grant_wdata", 32'(mem_data_write), 32'(wdata[win]));
            r_to  = 1'b0;
            r_lat = 0;
            if (stall || lat_ovr == -2) r_to = 1'b1;
            else if (lat_ovr >= 0)      r_lat = lat_ovr;
            else begin
                r = int'($urandom_range(0, 9));
                if (r < 6)      r_lat = r % 4;
                else if (r < 9) r_lat = int'($urandom_range(4, TO));
                else            r_to = 1'b1;
            end
            if (we[win]) begin
                data = last_rd[win];
                if (!r_to) mem[addr[win]] = wdata[win];
                mem_data_read = 16'($urandom);
            end else begin
                if (mem.exists(addr[win])) data = mem[addr[win]];
                else begin
                    data = 16'($urandom);
                    mem[addr[win]] = data;
                end
                mem_data_read = r_to ? 16'($urandom) : data;
            end
            e.port = win;
            e.err  = r_to;
            e.data = r_to ? 16'hFFFF : data;
            e.due  = cyc + (r_to ? TO : r_lat) + 1;
            last_rd[win] = e.data;
            exp_q.push_back(e);
            r_active = 1'b1;
            r_cnt    = 0;
            if (!r_to && r_lat == 0) mem_ready = 1'b1;
        endtask

        // SRAM controller model and expectation producer.
        always @(negedge clk) begin
            if (!rst_n) begin
                r_active  = 1'b0;
                mem_ready = 1'b0;
                exp_q.delete();
                m_owner   = 1'b1;
                m_starve  = 0;
                last_rd[0] = 16'd0;
                last_rd[1] = 16'd0;
            end else if (r_active) begin
                if (!(mem_read || mem_write)) begin
                    r_active  = 1'b0;
                    mem_ready = 1'b0;
                end else begin
                    r_cnt++;
                    if (!r_to && r_cnt == r_lat) mem_ready = 1'b1;
                end
            end else if (mem_read || mem_write) begin
                start_access();
            end
        end

        // Response monitor: pops the scoreboard on every ack.
        logic [15:0] held [2];
        exp_t        m_e;
        always @(negedge clk) begin
            if (!rst_n) begin
                held[0] = 16'd0;
                held[1] = 16'd0;
            end else if (ack0 || ack1) begin
                chk("exp_pending", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    chk("ack_port", 32'({ack1, ack0}), (m_e.port == 1) ? 32'd2 : 32'd1);
                    chk("ack_err", 32'({err1, err0}), (m_e.port == 1) ? 32'({m_e.err, 1'b0}) : 32'({1'b0, m_e.err}));
                    chk("ack_rdata", 32'((m_e.port == 1) ? rdata1 : rdata0), 32'(m_e.data));
                    chk("ack_other_rdata", 32'((m_e.port == 1) ? rdata0 : rdata1), 32'((m_e.port == 1) ? held[0] : held[1]));
                    chk("ack_cycle", 32'(cyc), 32'(m_e.due));
                    held[m_e.port] = m_e.data;
                end
            end else begin
                chk("idle_hold", {rdata1, rdata0}, {held[1], held[0]});
                chk("idle_err", 32'({err1, err0}), 32'd0);
            end
        end

        function automatic logic ackp(input int p);
            return (p == 1) ? ack1 : ack0;
        endfunction

        task automatic new_req(input int p);
            req[p]   = 1'b1;
            we[p]    = 1'($urandom_range(0, 1));
            addr[p]  = 18'h12340 | 18'($urandom_range(0, 7));
            wdata[p] = 16'($urandom);
        endtask

        task automatic step();
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (req[p] && ackp(p)) begin
                    if (mode == M_HOLD || (mode == M_RAND && $urandom_range(0, 1) == 1)) new_req(p);
                    else req[p] = 1'b0;
                end else if (!req[p] && mode == M_RAND && $urandom_range(0, 3) == 0) begin
                    new_req(p);
                end
            end
        endtask

        task automatic do_access(input int p, input logic w, input logic [17:0] a,
                                 input logic [15:0] dat, input int lat);
            lat_ovr  = lat;
            we[p]    = w;
            addr[p]  = a;
            wdata[p] = dat;
            req[p]   = 1'b1;
            for (int i = 0; i < 40 && req[p]; i++) step();
            chk("access_acked", 32'(req[p]), 32'd0);
            req[p] = 1'b0;
        endtask

        initial begin
            int base;
            for (int p = 0; p < 2; p++) begin
                req[p] = 1'b0; we[p] = 1'b0; addr[p] = 18'd0; wdata[p] = 16'd0;
            end
            repeat (3) @(negedge clk);
            chk("rst_ctrl", 32'({ack1, ack0, err1, err0, mem_read, mem_write, busy}), 32'd0);
            chk("rst_owner", 32'(owner), 32'd1);
            chk("rst_rdata", {rdata1, rdata0}, 32'd0);
            chk("rst_mem_address", 32'(mem_address), 32'd0);
            chk("rst_mem_data_write", 32'(mem_data_write), 32'd0);
            #2 rst_n = 1'b1;

            // Abort an access mid-BUSY with reset, then restart with both ports requesting.
            stall = 1'b1;
            we[0] = 1'b0; addr[0] = 18'h00777; req[0] = 1'b1;
            for (int i = 0; i < 10 && !mem_read; i++) @(negedge clk);
            chk("abort_started", 32'(mem_read), 32'd1);
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("abort_strobes", 32'({mem_read, mem_write, busy, ack1, ack0}), 32'd0);
            stall = 1'b0;
            we[1] = 1'b0; addr[1] = 18'h12341; req[1] = 1'b1;
            mode = M_HOLD;
            lat_ovr = 0;
            repeat (2) @(negedge clk);
            chk("abort_idle", 32'({ack1, ack0, owner}), 32'd1);
            #2 rst_n = 1'b1;

            base = grant_log.size();
            for (int i = 0; i < 60 && grant_log.size() < base + 10; i++) step();
            chk("seq_len", 32'(grant_log.size() >= base + 10), 32'd1);
            for (int i = 0; i < 10; i++) begin
                if (base + i < grant_log.size())
                    chk($sformatf("seq_grant%0d", i), 32'(grant_log[base + i]),
                        (d == 1) ? 32'(i % 5 == 4) : 32'(i % 2));
                if (base + i + 1 < grant_cyc.size() && i < 9)
                    chk($sformatf("seq_gap%0d", i), 32'(grant_cyc[base + i + 1] - grant_cyc[base + i]), 32'd3);
            end
            mode = M_OFF;
            for (int i = 0; i < 40 && (req[0] || req[1]); i++) step();
            chk("seq_drained", 32'({req[1], req[0]}), 32'd0);

            // Directed: write then read back, timeouts, and ready on the timeout cycle.
            do_access(1, 1'b1, 18'h12345, 16'h0042, 1);
            do_access(0, 1'b0, 18'h12345, 16'h0000, 1);
            do_access(1, 1'b0, 18'h00100, 16'h0000, -2);
            do_access(0, 1'b1, 18'h00200, 16'h1234, -2);
            do_access(0, 1'b0, 18'h00200, 16'h0000, 0);
            do_access(1, 1'b0, 18'h12345, 16'h0000, TO);

            lat_ovr = -1;
            mode = M_RAND;
            repeat (800) step();
            mode = M_OFF;
            for (int i = 0; i < 80 && (req[0] || req[1] || busy); i++) step();
            chk("final_idle", 32'({req[1], req[0], busy}), 32'd0);
            chk("final_queue", 32'(exp_q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(g_env[0].done && g_env[1].done); i++) @(negedge clk);
        check("envs_finished", 32'(g_env[0].done && g_env[1].done), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
